// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: upstream request/bypass inputs and the registered operand
// pair handed to the ALU. "slave" is the stage's view; "master" is the environment's.
interface alu_operand_stage_if #(
    parameter int DWIDTH = 16,
    parameter int OFFW   = 8,
    parameter int AWIDTH = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              a_sel;
    logic [1:0]        b_sel;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH-1:0] rs_addr;
    logic [DWIDTH-1:0] rd_q;
    logic [DWIDTH-1:0] rs_q;
    logic [OFFW-1:0]   offset;
    logic              wb_en;
    logic [AWIDTH-1:0] wb_addr;
    logic [DWIDTH-1:0] wb_data;
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_valid, a_sel, b_sel, rd_addr, rs_addr, rd_q, rs_q, offset,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, alu_a, alu_b, out_valid
    );

    modport master (
        output in_valid, a_sel, b_sel, rd_addr, rs_addr, rd_q, rs_q, offset,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, alu_a, alu_b, out_valid
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves write-back bypass and immediate formatting at
// acceptance, then buffers operand pairs in a 2-entry (head + skid) in-order buffer.
module alu_operand_stage #(
    parameter int DWIDTH = 16,
    parameter int OFFW   = 8,
    parameter int AWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_stage_if.slave   bus
);
    localparam int EXTW = DWIDTH - OFFW;

    logic [1:0]        count;
    logic [DWIDTH-1:0] head_a, head_b;
    logic [DWIDTH-1:0] skid_a, skid_b;
    logic [DWIDTH-1:0] rd_val, rs_val, new_a, new_b;
    logic              accept, consume;

    // Operands are frozen at acceptance; later write-backs never touch buffered entries.
    always_comb begin
        rd_val = bus.rd_q;
        rs_val = bus.rs_q;
        if (bus.wb_en && (bus.wb_addr == bus.rd_addr)) rd_val = bus.wb_data;
        if (bus.wb_en && (bus.wb_addr == bus.rs_addr)) rs_val = bus.wb_data;

        new_a = bus.a_sel ? '0 : rd_val;
        new_b = rs_val;
        case (bus.b_sel)
            2'b00: new_b = rs_val;
            2'b01: new_b = {{EXTW{bus.offset[OFFW-1]}}, bus.offset};
            2'b10: new_b = {{EXTW{1'b0}}, bus.offset};
            2'b11: new_b = {bus.offset, {EXTW{1'b0}}};
            default: new_b = rs_val;
        endcase
    end

    // Ready depends only on registered occupancy.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.alu_a     = head_a;
    assign bus.alu_b     = head_b;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head_a <= '0;
            head_b <= '0;
            skid_a <= '0;
            skid_b <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (accept) begin
                        head_a <= new_a;
                        head_b <= new_b;
                        count  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && consume) begin
                        head_a <= new_a;
                        head_b <= new_b;
                    end else if (accept) begin
                        skid_a <= new_a;
                        skid_b <= new_b;
                        count  <= 2'd2;
                    end else if (consume) begin
                        // Head keeps its last value once drained.
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (consume) begin
                        head_a <= skid_a;
                        head_b <= skid_b;
                        count  <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, operand formation, bypass,
// backpressure ordering and mid-operation reset.
module tb_alu_operand_stage;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    alu_operand_stage_if #(.DWIDTH(16), .OFFW(8), .AWIDTH(3)) bus ();

    alu_operand_stage #(.DWIDTH(16), .OFFW(8), .AWIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic as, input logic [1:0] bs,
                           input logic [15:0] rdq, input logic [15:0] rsq,
                           input logic [7:0] off);
        bus.in_valid = v;
        bus.a_sel    = as;
        bus.b_sel    = bs;
        bus.rd_q     = rdq;
        bus.rs_q     = rsq;
        bus.offset   = off;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        compared++; if (bus.alu_a !== 16'h0000) begin mismatched++; $display("FAIL reset_alu_a got %h exp 0000", bus.alu_a); end
        compared++; if (bus.alu_b !== 16'h0000) begin mismatched++; $display("FAIL reset_alu_b got %h exp 0000", bus.alu_b); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        set_req(1'b1, 1'b0, 2'b00, 16'h1234, 16'h00FF, 8'h00);
        step();
        set_req(1'b0, 1'b0, 2'b00, 16'h5555, 16'h6666, 8'h00);
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_out_valid got %b exp 1", bus.out_valid); end
        compared++; if (bus.alu_a !== 16'h1234) begin mismatched++; $display("FAIL basic_alu_a got %h exp 1234", bus.alu_a); end
        compared++; if (bus.alu_b !== 16'h00FF) begin mismatched++; $display("FAIL basic_alu_b got %h exp 00ff", bus.alu_b); end
        step();
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL drain_out_valid got %b exp 0", bus.out_valid); end
        compared++; if (bus.alu_a !== 16'h1234) begin mismatched++; $display("FAIL drain_hold_a got %h exp 1234", bus.alu_a); end
    endtask

    task automatic test_offsets();
        logic [1:0]  sel_tbl [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
        logic [7:0]  off_tbl [4] = '{8'h80, 8'h80, 8'h80, 8'h7F};
        logic [15:0] exp_tbl [4] = '{16'hFF80, 16'h0080, 16'h8000, 16'h007F};
        bus.out_ready = 1'b1;
        // Back-to-back with consume each cycle: head is replaced every edge.
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b1, sel_tbl[i], 16'hAAAA, 16'h1111, off_tbl[i]);
            step();
            compared++; if (bus.alu_b !== exp_tbl[i]) begin mismatched++; $display("FAIL offset_b[%0d] got %h exp %h", i, bus.alu_b, exp_tbl[i]); end
            compared++; if (bus.alu_a !== 16'h0000) begin mismatched++; $display("FAIL a_zero[%0d] got %h exp 0000", i, bus.alu_a); end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        bus.out_ready = 1'b1;
        set_req(1'b1, 1'b0, 2'b00, 16'h0001, 16'h0002, 8'h00);
        bus.rd_addr = 3'd3; bus.rs_addr = 3'd5;
        bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'hBEEF;
        step();
        compared++; if (bus.alu_a !== 16'hBEEF) begin mismatched++; $display("FAIL bypass_rd_hit got %h exp beef", bus.alu_a); end
        compared++; if (bus.alu_b !== 16'h0002) begin mismatched++; $display("FAIL bypass_rs_miss got %h exp 0002", bus.alu_b); end
        bus.wb_addr = 3'd4;
        step();
        compared++; if (bus.alu_a !== 16'h0001) begin mismatched++; $display("FAIL bypass_rd_miss got %h exp 0001", bus.alu_a); end
        bus.wb_addr = 3'd5; bus.wb_data = 16'hCAFE;
        step();
        compared++; if (bus.alu_b !== 16'hCAFE) begin mismatched++; $display("FAIL bypass_rs_hit got %h exp cafe", bus.alu_b); end
        bus.wb_en = 1'b0;
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_no_update();
        bus.out_ready = 1'b0;
        set_req(1'b1, 1'b0, 2'b00, 16'h1111, 16'h2222, 8'h00);
        bus.rd_addr = 3'd2; bus.rs_addr = 3'd6;
        step();
        bus.in_valid = 1'b0;
        bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'h9999;
        step();
        compared++; if (bus.alu_a !== 16'h1111) begin mismatched++; $display("FAIL no_late_bypass got %h exp 1111", bus.alu_a); end
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        step();
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL no_update_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        set_req(1'b1, 1'b0, 2'b00, 16'h000A, 16'h00A0, 8'h00);
        step();
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_after_A got %b exp 1", bus.in_ready); end
        set_req(1'b1, 1'b0, 2'b00, 16'h000B, 16'h00B0, 8'h00);
        step();
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_after_B got %b exp 0", bus.in_ready); end
        set_req(1'b1, 1'b0, 2'b00, 16'h000C, 16'h00C0, 8'h00);
        step();
        step();
        compared++; if (bus.alu_a !== 16'h000A) begin mismatched++; $display("FAIL b2b_hold_a got %h exp 000a", bus.alu_a); end
        compared++; if (bus.alu_b !== 16'h00A0) begin mismatched++; $display("FAIL b2b_hold_b got %h exp 00a0", bus.alu_b); end
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_c_held_off got %b exp 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        compared++; if (bus.alu_a !== 16'h000B) begin mismatched++; $display("FAIL b2b_order_B got %h exp 000b", bus.alu_a); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_reopen got %b exp 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        compared++; if (bus.alu_a !== 16'h000C || bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_order_C got %h/%b exp 000c/1", bus.alu_a, bus.out_valid); end
        step();
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_no_dup got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        set_req(1'b1, 1'b0, 2'b00, 16'h0123, 16'h0456, 8'h00);
        step();
        set_req(1'b1, 1'b0, 2'b00, 16'h0789, 16'h0ABC, 8'h00);
        step();
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL rstmid_full got %b exp 0", bus.in_ready); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
        compared++; if (bus.alu_a !== 16'h0000 || bus.alu_b !== 16'h0000) begin mismatched++; $display("FAIL rstmid_alu got %h/%h exp 0000/0000", bus.alu_a, bus.alu_b); end
        bus.out_ready = 1'b0;
        set_req(1'b1, 1'b0, 2'b00, 16'h0D0D, 16'h0E0E, 8'h00);
        step();
        bus.in_valid = 1'b0;
        compared++; if (bus.alu_a !== 16'h0D0D || bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_first got %h/%b exp 0d0d/1", bus.alu_a, bus.out_valid); end
        bus.out_ready = 1'b1;
        step();
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_skid_gone got %b exp 0", bus.out_valid); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
        bus.rd_addr   = 3'd0;
        bus.rs_addr   = 3'd1;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 3'd7;
        bus.wb_data   = 16'h0000;
        bus.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_offsets();
        test_bypass();
        test_no_update();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
